// File: rtl/train_sensor_tracker.sv
// Train sensor tracker: synchronises the track sensors, follows the train
// through them in order, measures the interval between sensors, predicts
// the next interval with a running average and counts it down. It also
// drives the gate command and the overdue/fault flags.
module train_sensor_tracker #(
    parameter int NUM_SENSORS = 6,
    parameter int STATE_W     = 4,
    parameter int TIME_W      = 19,
    parameter int DEFAULT_T   = 250000,
    parameter int GATE_SENSOR = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensor,
    output logic [STATE_W-1:0]     present_state,
    output logic [TIME_W-1:0]      time_meas,
    output logic [TIME_W-1:0]      time_pred,
    output logic [TIME_W-1:0]      timer,
    output logic                   timer_done,
    output logic                   gate_close,
    output logic                   overdue,
    output logic                   fault
);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, FAULT} mode_t;

    localparam logic [TIME_W-1:0]      T_DEF     = TIME_W'(DEFAULT_T);
    localparam logic [TIME_W-1:0]      T_MAX     = '1;
    localparam logic [STATE_W-1:0]     LAST_POS  = STATE_W'(NUM_SENSORS);
    localparam logic [STATE_W-1:0]     GATE_POS  = STATE_W'(GATE_SENSOR);
    localparam logic [NUM_SENSORS-1:0] HIT_FIRST = NUM_SENSORS'(1);
    localparam logic [NUM_SENSORS-1:0] HIT_LAST  = HIT_FIRST << (NUM_SENSORS - 1);

    logic [NUM_SENSORS-1:0] sync_a, sync_b, sync_prev, hit;
    mode_t                  mode, mode_nxt;
    logic [STATE_W-1:0]     pos, pos_nxt;
    logic [TIME_W-1:0]      cnt, cnt_nxt;
    logic [TIME_W-1:0]      meas_nxt, pred_nxt, timer_nxt;
    logic [TIME_W-1:0]      meas_new, pred_new;
    logic                   done_nxt, overdue_nxt;
    logic                   accept, restart, seq_err;

    // Two-flop synchroniser plus a previous-value flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_prev <= '0;
        end else begin
            sync_a    <= sensor;
            sync_b    <= sync_a;
            sync_prev <= sync_b;
        end
    end

    assign hit = sync_b & ~sync_prev;

    // Interval measured at an accepted hit counts the hit cycle itself, so it
    // is the counter plus one (saturating); the prediction is the new interval
    // on the first leg and a truncating running average afterwards.
    assign meas_new = (cnt == T_MAX) ? T_MAX : cnt + 1'b1;
    assign pred_new = (pos == STATE_W'(1)) ? meas_new
                    : TIME_W'(({1'b0, time_pred} + {1'b0, meas_new}) >> 1);

    // Next-state logic: classify the hit pattern for the current mode, then
    // apply fault entry, restart, acceptance or timer countdown in that order.
    always_comb begin
        mode_nxt    = mode;
        pos_nxt     = pos;
        cnt_nxt     = (cnt == T_MAX) ? cnt : cnt + 1'b1;
        meas_nxt    = time_meas;
        pred_nxt    = time_pred;
        timer_nxt   = timer;
        done_nxt    = 1'b0;
        overdue_nxt = overdue;
        accept      = 1'b0;
        restart     = 1'b0;
        seq_err     = 1'b0;

        case (mode)
            IDLE: begin
                if (hit == HIT_FIRST)  restart = 1'b1;
                else if (hit != '0)    seq_err = 1'b1;
            end
            TRACK: begin
                if (hit == (HIT_FIRST << pos))                accept  = 1'b1;
                else if (hit == (HIT_FIRST << (pos - 1'b1)))  accept  = 1'b0;
                else if (hit != '0)                           seq_err = 1'b1;
            end
            HOLD: begin
                if (hit != '0 && hit != HIT_LAST) seq_err = 1'b1;
            end
            FAULT: begin
                if (hit == HIT_FIRST) restart = 1'b1;
            end
            default: seq_err = 1'b1;
        endcase

        if (seq_err) begin
            mode_nxt    = FAULT;
            overdue_nxt = 1'b0;
        end else if (restart) begin
            mode_nxt    = TRACK;
            pos_nxt     = STATE_W'(1);
            cnt_nxt     = '0;
            timer_nxt   = T_DEF;
            overdue_nxt = 1'b0;
        end else if (accept) begin
            pos_nxt     = pos + 1'b1;
            mode_nxt    = (pos + 1'b1 == LAST_POS) ? HOLD : TRACK;
            cnt_nxt     = '0;
            meas_nxt    = meas_new;
            pred_nxt    = pred_new;
            timer_nxt   = pred_new;
            overdue_nxt = 1'b0;
        end else if (mode != FAULT && timer != '0) begin
            timer_nxt = timer - 1'b1;
            if (timer == TIME_W'(1)) begin
                done_nxt = 1'b1;
                if (mode == TRACK) overdue_nxt = 1'b1;
                if (mode == HOLD) begin
                    mode_nxt    = IDLE;
                    pos_nxt     = '0;
                    overdue_nxt = 1'b0;
                end
            end
        end
    end

    // State, measurement, prediction and timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode       <= IDLE;
            pos        <= '0;
            cnt        <= '0;
            time_meas  <= '0;
            time_pred  <= T_DEF;
            timer      <= '0;
            timer_done <= 1'b0;
            overdue    <= 1'b0;
        end else begin
            mode       <= mode_nxt;
            pos        <= pos_nxt;
            cnt        <= cnt_nxt;
            time_meas  <= meas_nxt;
            time_pred  <= pred_nxt;
            timer      <= timer_nxt;
            timer_done <= done_nxt;
            overdue    <= overdue_nxt;
        end
    end

    assign fault         = (mode == FAULT);
    assign present_state = fault ? '1 : pos;
    assign gate_close    = fault || (pos > GATE_POS);

endmodule

// File: tb/tb_train_sensor_tracker.sv
// Self-checking bench for train_sensor_tracker with three sensors and an
// 8-bit time base. Directed vectors with hand-computed expectations, plus
// hand-written sequences for idle-after-reset and asynchronous reset.
module tb_train_sensor_tracker;

    logic       clk;
    logic       rst;
    logic [2:0] sensor;
    logic [3:0] present_state;
    logic [7:0] time_meas, time_pred, timer;
    logic       timer_done, gate_close, overdue, fault;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        int         idle;
        logic [2:0] sens;
        int         settle;
        logic [3:0] ps;
        logic [7:0] meas;
        logic [7:0] pred;
        logic [7:0] tmr;
        logic       done;
        logic       gate;
        logic       ovd;
        logic       flt;
    } vec_t;

    vec_t vecs[$];

    train_sensor_tracker #(
        .NUM_SENSORS(3),
        .STATE_W    (4),
        .TIME_W     (8),
        .DEFAULT_T  (50),
        .GATE_SENSOR(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor       (sensor),
        .present_state(present_state),
        .time_meas    (time_meas),
        .time_pred    (time_pred),
        .timer        (timer),
        .timer_done   (timer_done),
        .gate_close   (gate_close),
        .overdue      (overdue),
        .fault        (fault)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] time limit reached");
    end

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic addVec(input string name, input int idle, input logic [2:0] sens,
                          input int settle, input logic [3:0] ps, input logic [7:0] meas,
                          input logic [7:0] pred, input logic [7:0] tmr, input logic done,
                          input logic gate, input logic ovd, input logic flt);
        vec_t v;
        v.name = name; v.idle = idle; v.sens = sens; v.settle = settle;
        v.ps = ps; v.meas = meas; v.pred = pred; v.tmr = tmr;
        v.done = done; v.gate = gate; v.ovd = ovd; v.flt = flt;
        vecs.push_back(v);
    endtask

    // Wait, pulse the sensors for one cycle, wait to settle, then check all outputs.
    task automatic applyStimulus(input vec_t v);
        repeat (v.idle) @(negedge clk);
        sensor = v.sens;
        @(negedge clk);
        sensor = 3'b000;
        repeat (v.settle - 1) @(negedge clk);
        checkOutput({v.name, ".present_state"}, 32'(present_state), 32'(v.ps));
        checkOutput({v.name, ".time_meas"},     32'(time_meas),     32'(v.meas));
        checkOutput({v.name, ".time_pred"},     32'(time_pred),     32'(v.pred));
        checkOutput({v.name, ".timer"},         32'(timer),         32'(v.tmr));
        checkOutput({v.name, ".timer_done"},    32'(timer_done),    32'(v.done));
        checkOutput({v.name, ".gate_close"},    32'(gate_close),    32'(v.gate));
        checkOutput({v.name, ".overdue"},       32'(overdue),       32'(v.ovd));
        checkOutput({v.name, ".fault"},         32'(fault),         32'(v.flt));
    endtask

    // Main test sequence.
    initial begin
        //      name              idle sens   set ps     meas pred tmr  dn gt ov ft
        addVec("s0_enter",        0,   3'b001, 3, 4'd1,  0,   50,  50,  0, 0, 0, 0);
        addVec("s1_hit",          17,  3'b010, 3, 4'd2,  20,  20,  20,  0, 1, 0, 0);
        addVec("s2_hit",          27,  3'b100, 3, 4'd3,  30,  25,  25,  0, 1, 0, 0);
        addVec("hold_t1",         23,  3'b000, 1, 4'd3,  30,  25,  1,   0, 1, 0, 0);
        addVec("hold_expire",     0,   3'b000, 1, 4'd0,  30,  25,  0,   1, 0, 0, 0);
        addVec("idle_after",      0,   3'b000, 1, 4'd0,  30,  25,  0,   0, 0, 0, 0);
        addVec("s0_again",        0,   3'b001, 3, 4'd1,  30,  25,  50,  0, 0, 0, 0);
        addVec("seq_err",         2,   3'b100, 3, 4'hF,  30,  25,  46,  0, 1, 0, 1);
        addVec("fault_frozen",    5,   3'b000, 1, 4'hF,  30,  25,  46,  0, 1, 0, 1);
        addVec("fault_recover",   0,   3'b001, 3, 4'd1,  30,  25,  50,  0, 0, 0, 0);
        addVec("overdue_expire",  49,  3'b000, 1, 4'd1,  30,  25,  0,   1, 0, 1, 0);
        addVec("overdue_hold",    0,   3'b000, 1, 4'd1,  30,  25,  0,   0, 0, 1, 0);
        addVec("bounce_s0",       0,   3'b001, 3, 4'd1,  30,  25,  0,   0, 0, 1, 0);
        addVec("sat_s1",          250, 3'b010, 3, 4'd2,  255, 255, 255, 0, 1, 0, 0);
        addVec("multi_hit",       0,   3'b110, 3, 4'hF,  255, 255, 253, 0, 1, 0, 1);
        addVec("recover2",        0,   3'b001, 3, 4'd1,  255, 255, 50,  0, 0, 0, 0);
        addVec("pre_collide",     47,  3'b010, 2, 4'd1,  255, 255, 1,   0, 0, 0, 0);
        addVec("collide",         0,   3'b000, 1, 4'd2,  50,  50,  50,  0, 1, 0, 0);
        addVec("hold_enter",      0,   3'b100, 3, 4'd3,  3,   26,  26,  0, 1, 0, 0);
        addVec("hold_t12",        13,  3'b000, 1, 4'd3,  3,   26,  12,  0, 1, 0, 0);

        rst    = 1'b1;
        sensor = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle after reset");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("idle.present_state", 32'(present_state), 32'd0);
            checkOutput("idle.timer_done",    32'(timer_done),    32'd0);
        end
        checkOutput("idle.time_pred",  32'(time_pred),  32'd50);
        checkOutput("idle.timer",      32'(timer),      32'd0);
        checkOutput("idle.gate_close", 32'(gate_close), 32'd0);
        checkOutput("idle.fault",      32'(fault),      32'd0);

        $display("[TB] running %0d directed vectors", vecs.size());
        foreach (vecs[i]) applyStimulus(vecs[i]);

        $display("[TB] asynchronous reset in HOLD");
        sensor = 3'b001;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst.present_state", 32'(present_state), 32'd0);
        checkOutput("arst.time_meas",     32'(time_meas),     32'd0);
        checkOutput("arst.time_pred",     32'(time_pred),     32'd50);
        checkOutput("arst.timer",         32'(timer),         32'd0);
        checkOutput("arst.timer_done",    32'(timer_done),    32'd0);
        checkOutput("arst.gate_close",    32'(gate_close),    32'd0);
        checkOutput("arst.overdue",       32'(overdue),       32'd0);
        checkOutput("arst.fault",         32'(fault),         32'd0);
        @(negedge clk);
        sensor = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("arst_drop.present_state", 32'(present_state), 32'd0);
        checkOutput("arst_drop.fault",         32'(fault),         32'd0);

        sensor = 3'b001;
        @(negedge clk);
        sensor = 3'b000;
        repeat (2) @(negedge clk);
        checkOutput("restart.present_state", 32'(present_state), 32'd1);
        checkOutput("restart.timer",         32'(timer),         32'd50);
        checkOutput("restart.time_pred",     32'(time_pred),     32'd50);
        checkOutput("restart.time_meas",     32'(time_meas),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
